// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: credit-based instruction fetch front-end with in-order queue and redirect flush.
module inst_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       stall,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [XLEN-1:0]            imem_rsp_data,
  output logic                       inst_valid,
  output logic [XLEN-1:0]            inst_pc,
  output logic [XLEN-1:0]            inst_data,
  output logic [$clog2(DEPTH):0]     queue_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = AW + 5;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [XLEN-1:0] pc_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] inflight_q, inflight_d, drop_q, drop_d;
  logic credit_ok, issue, rsp_ok, wr_req, keep, pop;
  assign imem_req_addr = fetch_pc_q;
  assign inst_valid = count_q != '0;
  assign inst_pc = pc_q[rd_ptr_q];
  assign inst_data = data_q[rd_ptr_q];
  assign queue_count = count_q;
  // rsp_pc tracks the PC of the next response that will be kept, so no per-request tag storage is needed
  always_comb begin
    credit_ok = (IW'(count_q) + inflight_q - drop_q) < IW'(DEPTH);
    imem_req_valid = reset && !redirect_valid && credit_ok && (inflight_q != '1);
    issue = imem_req_valid && imem_req_ready;
    rsp_ok = imem_rsp_valid && (inflight_q != '0);
    wr_req = rsp_ok && (drop_q == '0) && !redirect_valid;
    keep = wr_req && (count_q != CW'(DEPTH));
    pop = inst_valid && !stall;
    fetch_pc_d = redirect_valid ? redirect_pc : issue ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    rsp_pc_d = redirect_valid ? redirect_pc : keep ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
    inflight_d = inflight_q + IW'(issue) - IW'(rsp_ok);
    drop_d = redirect_valid ? inflight_q - IW'(rsp_ok) : drop_q - IW'(rsp_ok && (drop_q != '0));
    count_d = redirect_valid ? '0 : count_q + CW'(keep) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(keep);
    rd_ptr_d = redirect_valid ? wr_ptr_q : rd_ptr_q + AW'(pop);
    pc_d = pc_q;
    data_d = data_q;
    if (keep) begin
      pc_d[wr_ptr_q] = rsp_pc_q;
      data_d[wr_ptr_q] = imem_rsp_data;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      pc_q <= '{default: '0};
      data_q <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      inflight_q <= '0;
      drop_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      pc_q <= pc_d;
      data_q <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
    end
  end
  assert property (@(posedge clk) disable iff (!reset) !(imem_rsp_valid && inflight_q == '0));
  assert property (@(posedge clk) disable iff (!reset) !(wr_req && count_q == CW'(DEPTH)));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: table vectors, hand-written corner sequences and a randomized run against a queue-based fetch model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 0, redirect_valid = 0, stall = 0, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
  logic imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, inst_pc, inst_data;
  logic [2:0] queue_count;
  always #5 clk = ~clk;
  inst_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data), .queue_count(queue_count)
  );
  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { bit stall, ready, e_rv, e_iv; logic [31:0] e_ra, e_ipc; int e_cnt; } vec_t;
  req_t req_q[$];
  logic [31:0] fifo_m[$];
  logic [31:0] fetch_m = '0;
  int tests = 0, fails = 0, cyc = 0, lat_min = 1, lat_max = 1;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F ^ {a[31:16], 16'h0};
  endfunction
  function automatic int live_cnt();
    int n = 0;
    foreach (req_q[i]) if (!req_q[i].stale) n++;
    return n;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic settle();
    imem_rsp_valid = req_q.size() > 0 && req_q[0].due <= cyc;
    imem_rsp_data = imem_rsp_valid ? memf(req_q[0].addr) : '0;
    #1;
  endtask
  task automatic tick();
    bit issue, pop;
    req_t r;
    int d;
    settle();
    check("req_valid", imem_req_valid, !redirect_valid && (fifo_m.size() + live_cnt() < DEPTH));
    check("req_addr", imem_req_addr, fetch_m);
    check("inst_valid", inst_valid, fifo_m.size() > 0);
    check("queue_count", queue_count, fifo_m.size());
    if (fifo_m.size() > 0 && !stall) begin
      check("pop_pc", inst_pc, fifo_m[0]);
      check("pop_data", inst_data, memf(fifo_m[0]));
    end
    pop = fifo_m.size() > 0 && !stall;
    issue = imem_req_valid && imem_req_ready;
    @(posedge clk);
    if (pop) void'(fifo_m.pop_front());
    if (imem_rsp_valid) begin
      r = req_q.pop_front();
      if (!r.stale && !redirect_valid) fifo_m.push_back(r.addr);
    end
    if (redirect_valid) begin
      fifo_m.delete();
      foreach (req_q[i]) req_q[i].stale = 1;
      fetch_m = redirect_pc;
    end
    if (issue) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (req_q.size() > 0 && d < req_q[$].due) d = req_q[$].due;
      req_q.push_back('{fetch_m, d, 1'b0});
      fetch_m = fetch_m + 32'd4;
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic do_reset();
    #2;
    reset = 0;
    redirect_valid = 0;
    stall = 0;
    imem_rsp_valid = 0;
    imem_rsp_data = '0;
    req_q.delete();
    fifo_m.delete();
    fetch_m = '0;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst_data", inst_data, 0);
    check("rst_queue_count", queue_count, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    imem_req_ready = 1;
    #1;
    check("post_rst_req_valid", imem_req_valid, 1);
    check("post_rst_req_addr", imem_req_addr, 32'h0);
  endtask
  task automatic wait_first(input logic [31:0] exp_pc, input string name);
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    check({name, "_valid"}, inst_valid, 1);
    check({name, "_pc"}, inst_pc, exp_pc);
  endtask
  initial begin
    vec_t tbl[11];
    tbl = '{
      '{0, 1, 1, 0, 32'h00, 32'h0, 0}, '{0, 1, 1, 0, 32'h04, 32'h0, 0},
      '{0, 1, 1, 1, 32'h08, 32'h0, 1}, '{1, 1, 1, 1, 32'h0C, 32'h4, 1},
      '{1, 1, 1, 1, 32'h10, 32'h4, 2}, '{1, 1, 0, 1, 32'h14, 32'h4, 3},
      '{1, 1, 0, 1, 32'h14, 32'h4, 4}, '{0, 1, 0, 1, 32'h14, 32'h4, 4},
      '{0, 1, 1, 1, 32'h14, 32'h8, 3}, '{0, 1, 1, 1, 32'h18, 32'hC, 2},
      '{0, 1, 1, 1, 32'h1C, 32'h10, 2}};
    @(negedge clk);
    do_reset();
    foreach (tbl[i]) begin
      stall = tbl[i].stall;
      imem_req_ready = tbl[i].ready;
      settle();
      check("tbl_req_valid", imem_req_valid, tbl[i].e_rv);
      check("tbl_req_addr", imem_req_addr, tbl[i].e_ra);
      check("tbl_inst_valid", inst_valid, tbl[i].e_iv);
      if (tbl[i].e_iv) check("tbl_inst_pc", inst_pc, tbl[i].e_ipc);
      check("tbl_count", queue_count, tbl[i].e_cnt);
      tick();
    end
    stall = 0;
    // 3-cycle memory, redirect while two requests are outstanding
    lat_min = 3;
    lat_max = 3;
    do_reset();
    for (int i = 0; i < 10 && req_q.size() < 2; i++) tick();
    redirect_valid = 1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 0;
    wait_first(32'h100, "lat3_redirect");
    repeat (12) tick();
    // redirect coinciding with a response and a pop, 1-cycle memory
    lat_min = 1;
    lat_max = 1;
    repeat (6) tick();
    #1;
    check("pre_redirect_inst_valid", inst_valid, 1);
    redirect_valid = 1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 0;
    check("redir_count", queue_count, 0);
    check("redir_n1_valid", inst_valid, 0);
    tick();
    check("redir_n2_valid", inst_valid, 0);
    tick();
    check("redir_n3_valid", inst_valid, 1);
    check("redir_n3_pc", inst_pc, 32'h100);
    // address wrap at the top of the space
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 0;
    repeat (8) tick();
    lat_max = 3;
    for (int i = 0; i < 1000; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      stall = ($urandom % 3) == 0;
      redirect_valid = ($urandom % 32) == 0;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    redirect_valid = 0;
    stall = 0;
    do_reset();
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
